laser_cover_score: RTL

// Downstream scoring stage for the two-circle laser placement engine. Snoops the

---
 rtl/laser_cover_score.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/laser_cover_score.sv
`default_nettype none
// ============================================================================
// Module      : laser_cover_score
// Description : Snoops the X/Y point stream and, on DONE, counts how many of
//               the stored points lie inside either of two circles.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_cover_score #(
  parameter int N_POINTS = 40,
  parameter int COORD_W  = 4,
  parameter int R2       = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  input  logic               DONE,
  output logic [5:0]         SCORE,
  output logic               SCORE_VALID,
  output logic               BUSY,
  output logic               ERR
);

  localparam int c_PTR_W   = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int c_SQ_W    = 2 * COORD_W;
  localparam int c_D_W     = 2 * COORD_W + 1;
  localparam int c_SCORE_W = 6;

  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(N_POINTS - 1);
  localparam logic [c_PTR_W-1:0] c_ONE  = c_PTR_W'(1);
  localparam logic [c_D_W-1:0]   c_R2   = c_D_W'(R2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_EVAL      = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [COORD_W-1:0]   r_px [N_POINTS];
  logic [COORD_W-1:0]   r_py [N_POINTS];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_ev_ptr;
  logic [COORD_W-1:0]   r_cx [2];
  logic [COORD_W-1:0]   r_cy [2];
  logic [c_SCORE_W-1:0] r_acc;
  logic [c_SCORE_W-1:0] r_score;
  logic                 r_score_valid;
  logic                 r_err;

  logic                 w_store;
  logic [c_PTR_W-1:0]   w_wr_addr;
  logic [COORD_W-1:0]   w_ev_x;
  logic [COORD_W-1:0]   w_ev_y;
  logic [1:0]           w_in_circle;
  logic                 w_hit;

  // An aborted frame (DONE in LOAD) must not store the coincident point.
  assign w_store   = IN_VALID && ((r_state == S_IDLE) || ((r_state == S_LOAD) && !DONE));
  assign w_wr_addr = (r_state == S_IDLE) ? '0 : r_wr_ptr;

  assign w_ev_x = r_px[r_ev_ptr];
  assign w_ev_y = r_py[r_ev_ptr];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_circle
      logic [COORD_W-1:0] w_dx;
      logic [COORD_W-1:0] w_dy;
      logic [c_SQ_W-1:0]  w_sqx;
      logic [c_SQ_W-1:0]  w_sqy;
      logic [c_D_W-1:0]   w_dist;

      assign w_dx   = (w_ev_x >= r_cx[g]) ? (w_ev_x - r_cx[g]) : (r_cx[g] - w_ev_x);
      assign w_dy   = (w_ev_y >= r_cy[g]) ? (w_ev_y - r_cy[g]) : (r_cy[g] - w_ev_y);
      assign w_sqx  = c_SQ_W'(w_dx) * c_SQ_W'(w_dx);
      assign w_sqy  = c_SQ_W'(w_dy) * c_SQ_W'(w_dy);
      assign w_dist = c_D_W'(w_sqx) + c_D_W'(w_sqy);
      assign w_in_circle[g] = (w_dist <= c_R2);
    end
  endgenerate

  // A point inside both circles still counts once.
  assign w_hit = |w_in_circle;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (IN_VALID) begin
          w_next_state = (N_POINTS == 1) ? S_WAIT_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (DONE) begin
          w_next_state = S_IDLE;
        end else if (IN_VALID && (r_wr_ptr == c_LAST)) begin
          w_next_state = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (DONE) begin
          w_next_state = S_EVAL;
        end
      end
      S_EVAL: begin
        if (r_ev_ptr == c_LAST) begin
          w_next_state = S_REPORT;
        end
      end
      S_REPORT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Point store is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (w_store) begin
      r_px[w_wr_addr] <= X;
      r_py[w_wr_addr] <= Y;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr      <= '0;
      r_ev_ptr      <= '0;
      r_acc         <= '0;
      r_score       <= '0;
      r_score_valid <= 1'b0;
      r_err         <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_cx[i] <= '0;
        r_cy[i] <= '0;
      end
    end else begin
      r_score_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_wr_ptr <= c_ONE;
            r_err    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (DONE) begin
            r_err    <= 1'b1;
            r_wr_ptr <= '0;
          end else if (IN_VALID) begin
            r_wr_ptr <= r_wr_ptr + c_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (DONE) begin
            r_cx[0]  <= C1X;
            r_cy[0]  <= C1Y;
            r_cx[1]  <= C2X;
            r_cy[1]  <= C2Y;
            r_acc    <= '0;
            r_ev_ptr <= '0;
          end
        end
        S_EVAL: begin
          r_acc    <= r_acc + c_SCORE_W'(w_hit);
          r_ev_ptr <= (r_ev_ptr == c_LAST) ? '0 : (r_ev_ptr + c_ONE);
        end
        S_REPORT: begin
          r_score       <= r_acc;
          r_score_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign SCORE       = r_score;
  assign SCORE_VALID = r_score_valid;
  assign ERR         = r_err;
  assign BUSY        = (r_state == S_LOAD) || (r_state == S_WAIT_DONE) || (r_state == S_EVAL);

endmodule
`default_nettype wire
